// File: rtl/sdram_pkg.sv
// Shared constants and state encodings for the SDRAM arbiter slice.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;

  localparam int TMO_W = 10;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit_wdog.sv
// Busy-state watchdog: counts cycles spent in a granted state and flags an expiry
// when the owner never signals its end. Only built with SDRAM_ARB_TIMEOUT_EN.
module sdram_arbit_wdog
  import sdram_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic state_chg,
  input  logic end_match,
  output logic expire,
  output logic err_timeout
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYC);

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // The owner's end flag beats the limit when both land in the same cycle.
  always_comb begin
    expire = busy && (cnt_q == LIMIT) && !end_match;
    cnt_d  = (state_chg || !busy) ? '0 : cnt_q + 1'b1;
    err_d  = expire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: grants refresh/write/read engines one at a time and muxes the
// owner's command/address onto the pins. Optional watchdog: SDRAM_ARB_TIMEOUT_EN.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter logic [3:0] CMD_NOP = 4'b0111
`ifdef SDRAM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1023
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        ref_req,
  output logic        ref_en,
  input  logic        flag_ref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [11:0] wr_addr,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] rd_addr,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic        sdram_cke,
  output logic [2:0]  arb_state,
  output logic        err_timeout
);

  arb_state_e state_q, state_d;
  logic       ref_en_q, ref_en_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic       cke_q;
  logic       expire;

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic busy;
  logic end_match;

  assign busy      = (state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ);
  assign end_match = ((state_q == ST_AREF)  && flag_ref_end) ||
                     ((state_q == ST_WRITE) && flag_wr_end)  ||
                     ((state_q == ST_READ)  && flag_rd_end);

  sdram_arbit_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy),
    .state_chg   (state_d != state_q),
    .end_match   (end_match),
    .expire      (expire),
    .err_timeout (err_timeout)
  );
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Every busy state exits to ARBIT, so back-to-back grants always see one ARBIT cycle.
  always_comb begin
    state_d  = state_q;
    ref_en_d = 1'b0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (flag_init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (ref_req) begin
          state_d  = ST_AREF;
          ref_en_d = 1'b1;
        end else if (wr_req) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
        end
      end
      ST_AREF:  if (flag_ref_end || expire) state_d = ST_ARBIT;
      ST_WRITE: if (flag_wr_end  || expire) state_d = ST_ARBIT;
      ST_READ:  if (flag_rd_end  || expire) state_d = ST_ARBIT;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      cke_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      ref_en_q <= ref_en_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      cke_q    <= 1'b1;
    end
  end

  // Mux is driven from the registered state only, so engine commands pass straight through.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = 12'd0;
    case (state_q)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 12'd0;
      end
    endcase
  end

  assign ref_en    = ref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign sdram_cke = cke_q;
  assign arb_state = state_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: table of per-cycle vectors plus hand-written
// sequences for asynchronous reset and the busy-state watchdog.
module tb_sdram_arbit;

  localparam logic [3:0]  I_CMD  = 4'b0010;
  localparam logic [11:0] I_ADDR = 12'h400;
  localparam logic [3:0]  A_CMD  = 4'b0001;
  localparam logic [11:0] A_ADDR = 12'h0AA;
  localparam logic [3:0]  W_CMD  = 4'b0100;
  localparam logic [11:0] W_ADDR = 12'h123;
  localparam logic [3:0]  R_CMD  = 4'b0101;
  localparam logic [11:0] R_ADDR = 12'h456;
  localparam logic [3:0]  NOP    = 4'b0111;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_init_end, ref_req, wr_req, rd_req;
  logic        flag_ref_end, flag_wr_end, flag_rd_end;
  logic        ref_en, wr_en, rd_en, sdram_cke, err_timeout;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [2:0]  arb_state;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0] in;  // {init_end, ref_req, wr_req, rd_req, ref_end, wr_end, rd_end}
    logic [2:0] st;
    logic [2:0] en;  // {ref_en, wr_en, rd_en}
  } vec_t;

  vec_t vecs[20];

  always #5 clk = ~clk;

  sdram_arbit dut (
    .clk           (clk),
    .rst           (rst),
    .flag_init_end (flag_init_end),
    .init_cmd      (I_CMD),
    .init_addr     (I_ADDR),
    .ref_req       (ref_req),
    .ref_en        (ref_en),
    .flag_ref_end  (flag_ref_end),
    .aref_cmd      (A_CMD),
    .aref_addr     (A_ADDR),
    .wr_req        (wr_req),
    .wr_en         (wr_en),
    .flag_wr_end   (flag_wr_end),
    .wr_cmd        (W_CMD),
    .wr_addr       (W_ADDR),
    .rd_req        (rd_req),
    .rd_en         (rd_en),
    .flag_rd_end   (flag_rd_end),
    .rd_cmd        (R_CMD),
    .rd_addr       (R_ADDR),
    .sdram_cmd     (sdram_cmd),
    .sdram_addr    (sdram_addr),
    .sdram_cke     (sdram_cke),
    .arb_state     (arb_state),
    .err_timeout   (err_timeout)
  );

  function automatic vec_t mk(input logic [6:0] in, input logic [2:0] st, input logic [2:0] en);
    vec_t v;
    v.in = in;
    v.st = st;
    v.en = en;
    return v;
  endfunction

  function automatic logic [15:0] exp_bus(input logic [2:0] st);
    case (st)
      3'd0:    return {I_CMD, I_ADDR};
      3'd2:    return {A_CMD, A_ADDR};
      3'd3:    return {W_CMD, W_ADDR};
      3'd4:    return {R_CMD, R_ADDR};
      default: return {NOP, 12'd0};
    endcase
  endfunction

  task automatic drive(input logic [6:0] in);
    {flag_init_end, ref_req, wr_req, rd_req, flag_ref_end, flag_wr_end, flag_rd_end} = in;
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [2:0] en,
                       input logic err_exp);
    logic [15:0] bus_exp;
    bus_exp = exp_bus(st);
    n_vec++;
    if (arb_state !== st || {ref_en, wr_en, rd_en} !== en || sdram_cmd !== bus_exp[15:12] ||
        sdram_addr !== bus_exp[11:0] || sdram_cke !== 1'b1 || err_timeout !== err_exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d en=%b cmd=%b addr=%h cke=%b err=%b, want st=%0d en=%b cmd=%b addr=%h cke=1 err=%b",
               name, arb_state, {ref_en, wr_en, rd_en}, sdram_cmd, sdram_addr, sdram_cke,
               err_timeout, st, en, bus_exp[15:12], bus_exp[11:0], err_exp);
    end
  endtask

  task automatic step(input logic [6:0] in);
    @(negedge clk);
    drive(in);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: simulation did not reach the summary");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0]  = mk(7'b0_100_000, 3'd0, 3'b000);  // requests ignored during init
    vecs[1]  = mk(7'b1_000_000, 3'd1, 3'b000);
    vecs[2]  = mk(7'b1_000_000, 3'd1, 3'b000);
    vecs[3]  = mk(7'b1_100_000, 3'd2, 3'b100);
    vecs[4]  = mk(7'b1_000_000, 3'd2, 3'b000);
    vecs[5]  = mk(7'b1_000_100, 3'd1, 3'b000);
    vecs[6]  = mk(7'b1_111_000, 3'd2, 3'b100);  // refresh wins
    vecs[7]  = mk(7'b1_011_000, 3'd2, 3'b000);
    vecs[8]  = mk(7'b1_011_100, 3'd1, 3'b000);  // end + pending req: no chaining
    vecs[9]  = mk(7'b1_011_000, 3'd3, 3'b010);
    vecs[10] = mk(7'b1_001_000, 3'd3, 3'b000);
    vecs[11] = mk(7'b1_001_101, 3'd3, 3'b000);  // foreign end flags ignored
    vecs[12] = mk(7'b1_001_010, 3'd1, 3'b000);
    vecs[13] = mk(7'b1_001_000, 3'd4, 3'b001);
    vecs[14] = mk(7'b1_000_000, 3'd4, 3'b000);
    vecs[15] = mk(7'b1_000_001, 3'd1, 3'b000);
    vecs[16] = mk(7'b1_010_000, 3'd3, 3'b010);
    vecs[17] = mk(7'b1_000_010, 3'd1, 3'b000);
    vecs[18] = mk(7'b1_001_000, 3'd4, 3'b001);
    vecs[19] = mk(7'b1_000_000, 3'd4, 3'b000);

    rst = 1'b1;
    drive(7'b0_100_000);
    #2;
    check("reset_state", 3'd0, 3'b000, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, 1'b0);
    end

    // Asynchronous reset while READ is held.
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_read", 3'd0, 3'b000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(7'b1_000_000);
    @(posedge clk);
    #1;
    check("rst_release_arbit", 3'd1, 3'b000, 1'b0);

    // Reset landing on the grant pulse cycle clears the enable at once.
    step(7'b1_001_000);
    check("rd_grant", 3'd4, 3'b001, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("rst_on_grant", 3'd0, 3'b000, 1'b0);
    step(7'b1_000_000);
    rst = 1'b0;
    check("rst_held", 3'd0, 3'b000, 1'b0);
    step(7'b1_000_000);
    check("after_rst_arbit", 3'd1, 3'b000, 1'b0);

    // Write owner never ends.
    step(7'b1_010_000);
    check("tmo_grant", 3'd3, 3'b010, 1'b0);
    @(negedge clk);
    drive(7'b1_000_000);
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk);
      #1;
`ifdef SDRAM_ARB_TIMEOUT_EN
      check($sformatf("tmo_cyc%0d", i), (i >= 1024) ? 3'd1 : 3'd3, 3'b000, i == 1024);
`else
      check($sformatf("tmo_cyc%0d", i), 3'd3, 3'b000, 1'b0);
`endif
    end
    step(7'b1_000_010);
    check("tmo_exit", 3'd1, 3'b000, 1'b0);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // End flag coincides with the limit: end flag wins, no error pulse.
    step(7'b1_010_000);
    check("tie_grant", 3'd3, 3'b010, 1'b0);
    @(negedge clk);
    drive(7'b1_000_000);
    for (int i = 1; i <= 1023; i++) @(posedge clk);
    step(7'b1_000_010);
    check("tie_end_wins", 3'd1, 3'b000, 1'b0);
    step(7'b1_000_000);
    check("tie_no_err", 3'd1, 3'b000, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
